// File: rtl/imm_packer.sv
// -----------------------------------------------------------------------------
// imm_packer
// Encoder side of the U/J immediate field. Each accepted request
// {specifier, imm, rd} is packed into the 25-bit opcode-stripped
// instruction_data layout that the decode-stage immediate extractor consumes.
// The packed word is buffered in a DEPTH-entry FIFO with valid/ready on both
// sides. The round trip decode(encode(x)) returns x for every legal x.
//
// Parameters
//   DEPTH  FIFO entries (power of 2, >= 2)
//   CNT_W  width of err_count
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      request valid
//   in_ready      FIFO can accept a request (= !full)
//   in_specifier  0 = U-type, 1 = J-type
//   in_imm[20:0]  immediate in the decoder's output format
//   in_rd[4:0]    destination register
//   out_valid     head entry valid (= !empty)
//   out_ready     consumer takes the head entry
//   out_data      packed instruction_data of the head entry
//   out_err       head entry was encoded from an illegal immediate
//   occupancy     number of entries held (0..DEPTH)
//   err_count     illegal requests accepted, saturating at all-ones
//
// Configuration macro: IMM_PACK_STRICT_EN
//   defined   - an illegal request completes its handshake but is dropped
//               instead of being buffered; out_err is always 0.
//   undefined - an illegal request is buffered with the offending bit
//               ignored, and the entry carries out_err = 1.
// -----------------------------------------------------------------------------
module imm_packer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_specifier,
  input  logic [20:0]              in_imm,
  input  logic [4:0]               in_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [24:0]              out_data,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         err_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  // Each entry stores {err, data}.
  logic [25:0]      mem [DEPTH];
  logic [25:0]      last_q;
  logic [25:0]      head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ_q;
  logic [CNT_W-1:0] err_q;

  logic [24:0] enc_data;
  logic        enc_illegal;
  logic        entry_err;
  logic        accept;
  logic        push;
  logic        pop;
  logic        err_inc;

  // Encode map. U-type keeps imm[20:1] (imm[0] must be zero); J-type
  // scatters imm[19:0] into the J field order (imm[20] must be zero).
  always_comb begin
    enc_data    = '0;
    enc_illegal = 1'b0;
    if (!in_specifier) begin
      enc_data    = {in_imm[20:1], in_rd};
      enc_illegal = in_imm[0];
    end else begin
      enc_data    = {in_imm[19], in_imm[9:0], in_imm[10], in_imm[18:11], in_rd};
      enc_illegal = in_imm[20];
    end
  end

  // in_ready depends only on registered occupancy, so a pop in the same
  // cycle never opens the input of a full FIFO.
  assign in_ready  = (occ_q != FULL_OCC);
  assign out_valid = (occ_q != '0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign err_inc   = accept && enc_illegal;

`ifdef IMM_PACK_STRICT_EN
  assign push      = accept && !enc_illegal;
  assign entry_err = 1'b0;
`else
  assign push      = accept;
  assign entry_err = enc_illegal;
`endif

  // Storage and pointers. The array is reset so the head read is never X,
  // and last_q remembers the most recently popped entry so the outputs
  // hold steady while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      last_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {entry_err, enc_data};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        last_q <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Occupancy is tracked separately from the wrapping pointers so that
  // full and empty are unambiguous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (push && !pop) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (err_inc && (err_q != '1)) begin
      err_q <= err_q + CNT_W'(1);
    end
  end

  assign head      = out_valid ? mem[rd_ptr] : last_q;
  assign out_data  = head[24:0];
  assign out_err   = head[25];
  assign occupancy = occ_q;
  assign err_count = err_q;

endmodule
